// File: rtl/srsw_arb_pkg.sv
// Shared defaults and slice helpers for the single-read/single-write port arbiter.
package srsw_arb_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int AW_DEFAULT   = 2;
  localparam int DW_DEFAULT   = 32;

  // Low bit of slice idx in a flattened per-requester bus of the given width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eligible,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/srsw_port_arbiter.sv
// Shares one single-read/single-write memory among NREQ requesters with
// independent read/write round-robin arbiters and one-entry response buffers.
module srsw_port_arbiter
  import srsw_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_waddr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_raddr,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] wr_elig;
  logic [NREQ-1:0] rd_elig;
  logic [NREQ-1:0] wr_grant;
  logic [NREQ-1:0] rd_grant;
  logic [NREQ-1:0] rsp_fire;
  logic            infl_valid;
  logic [TW-1:0]   infl_tag;
  logic [TW-1:0]   rd_idx;

  // Eligibility is masked during reset so every output is quiet while rst is high.
  assign wr_elig  = rst ? '0 : (req_valid & req_we);
  assign rd_elig  = rst ? '0 : (req_valid & ~req_we & ~pend);
  assign rsp_fire = rsp_valid & rsp_ready;

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (wr_elig),
    .grant    (wr_grant)
  );

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (rd_elig),
    .grant    (rd_grant)
  );

  // A requester is either a writer or a reader in a given cycle, so the grants never overlap.
  assign req_ready = wr_grant | rd_grant;

  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    rd_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_grant[i]) begin
        mem_wen   = 1'b1;
        mem_waddr = req_addr[slice_lo(i, AW) +: AW];
        mem_wdata = req_wdata[slice_lo(i, DW) +: DW];
      end
      if (rd_grant[i]) begin
        mem_ren   = 1'b1;
        mem_raddr = req_addr[slice_lo(i, AW) +: AW];
        rd_idx    = TW'(i);
      end
    end
  end

  // The response register doubles as the read buffer: memory data lands in the
  // tagged requester's slice one cycle after the grant and is visible the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      infl_valid <= 1'b0;
      infl_tag   <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      infl_valid <= mem_ren;
      infl_tag   <= rd_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (rd_grant[i]) begin
          pend[i] <= 1'b1;
        end else if (rsp_fire[i]) begin
          pend[i] <= 1'b0;
        end
        if (rsp_fire[i]) begin
          rsp_valid[i] <= 1'b0;
        end else if (infl_valid && infl_tag == TW'(i)) begin
          rsp_valid[i]                      <= 1'b1;
          rsp_rdata[slice_lo(i, DW) +: DW] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_srsw_port_arbiter.sv
// Bench for srsw_port_arbiter: table vectors, directed corner sequences and
// random traffic against a cycle-level reference model with its own memory image.
module tb_srsw_port_arbiter;
  import srsw_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 2;
  localparam int DW   = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*DW-1:0] rsp_rdata;
  logic [NREQ-1:0]    rsp_ready;
  logic               mem_wen;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_ren;
  logic [AW-1:0]      mem_raddr;
  logic [DW-1:0]      mem_rdata;

  srsw_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_ready (rsp_ready),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory instance: registered read, read-before-write, cleared by reset.
  logic [DW-1:0] mem_arr [1<<AW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1<<AW); i++) mem_arr[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_ren) mem_rdata <= mem_arr[mem_raddr];
      if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
    end
  end

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: priority pointers, pending flag, due cycle and data per requester.
  int            ptr_w, ptr_r, cyc;
  bit            m_pend [NREQ];
  int            m_due  [NREQ];
  logic [DW-1:0] m_data [NREQ];
  logic [DW-1:0] ref_mem [1<<AW];
  logic [NREQ-1:0] last_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_w = 0;
    ptr_r = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 1'b0;
      m_due[i]  = 0;
      m_data[i] = '0;
    end
    for (int a = 0; a < (1<<AW); a++) ref_mem[a] = '0;
    last_ready = '0;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] data);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_wdata[i*DW +: DW] = data;
  endtask

  // Compare one cycle against the model, then advance the model across the edge.
  task automatic step();
    int              wg, rg;
    logic [NREQ-1:0] e_ready, e_rv;
    logic [AW-1:0]   e_wa, e_ra;
    logic [DW-1:0]   e_wd;
    #1;
    wg = -1;
    rg = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_w + k) % NREQ;
      if (wg < 0 && req_valid[i] && req_we[i]) wg = i;
    end
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_r + k) % NREQ;
      if (rg < 0 && req_valid[i] && !req_we[i] && !m_pend[i]) rg = i;
    end
    e_ready = '0;
    e_wa = '0; e_wd = '0; e_ra = '0;
    if (wg >= 0) begin
      e_ready[wg] = 1'b1;
      e_wa = req_addr[wg*AW +: AW];
      e_wd = req_wdata[wg*DW +: DW];
    end
    if (rg >= 0) begin
      e_ready[rg] = 1'b1;
      e_ra = req_addr[rg*AW +: AW];
    end
    for (int i = 0; i < NREQ; i++) e_rv[i] = m_pend[i] && (cyc >= m_due[i]);

    check("req_ready", req_ready, e_ready);
    check("mem_wen",   mem_wen,   wg >= 0);
    check("mem_waddr", mem_waddr, e_wa);
    check("mem_wdata", mem_wdata, e_wd);
    check("mem_ren",   mem_ren,   rg >= 0);
    check("mem_raddr", mem_raddr, e_ra);
    check("rsp_valid", rsp_valid, e_rv);
    for (int i = 0; i < NREQ; i++)
      if (e_rv[i]) check("rsp_rdata", rsp_rdata[i*DW +: DW], m_data[i]);
    last_ready = req_ready;

    for (int i = 0; i < NREQ; i++)
      if (e_rv[i] && rsp_ready[i]) m_pend[i] = 1'b0;
    if (rg >= 0) begin
      m_pend[rg] = 1'b1;
      m_data[rg] = ref_mem[e_ra];
      m_due[rg]  = cyc + 2;
      ptr_r      = (rg + 1) % NREQ;
    end
    if (wg >= 0) begin
      ref_mem[e_wa] = e_wd;
      ptr_w         = (wg + 1) % NREQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Raise reset without touching the inputs; outputs must be quiet before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_wen",   mem_wen,   0);
    check("rst_mem_ren",   mem_ren,   0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata_lo",  rsp_rdata[63:0],   0);
    check("rst_rdata_hi",  rsp_rdata[127:64], 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] we;
    logic [NREQ-1:0] exp_ready;
    logic            exp_wen;
    logic [AW-1:0]   exp_waddr;
    logic            exp_ren;
    logic [AW-1:0]   exp_raddr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g2, a2;
    rst = 1'b1;
    idle();
    rsp_ready = '1;
    cyc = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Priority from a freshly reset pointer; requester i uses address i.
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[1] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
    vecs[2] = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1, 2'd0};
    vecs[3] = '{4'b1010, 4'b1000, 4'b1010, 1'b1, 2'd3, 1'b1, 2'd1};
    vecs[4] = '{4'b0110, 4'b0100, 4'b0110, 1'b1, 2'd2, 1'b1, 2'd1};
    vecs[5] = '{4'b1100, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1, 2'd2};
    vecs[6] = '{4'b1111, 4'b0101, 4'b0011, 1'b1, 2'd0, 1'b1, 2'd1};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      idle();
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i*AW +: AW]  = AW'(i);
        req_wdata[i*DW +: DW] = DW'(32'h100 + i);
      end
      req_valid = vecs[v].valid;
      req_we    = vecs[v].we;
      #1;
      check("vec_ready", req_ready, vecs[v].exp_ready);
      check("vec_wen",   mem_wen,   vecs[v].exp_wen);
      check("vec_waddr", mem_waddr, vecs[v].exp_waddr);
      check("vec_ren",   mem_ren,   vecs[v].exp_ren);
      check("vec_raddr", mem_raddr, vecs[v].exp_raddr);
      idle();
    end
    do_reset();

    // Write burst from all requesters: grants rotate 0..3 then wrap to 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, DW'(32'h100 + i));
    for (int k = 0; k < NREQ; k++) begin
      #1;
      check("burst_grant", req_ready, 4'b0001 << k);
      check("burst_wdata", mem_wdata, 32'h100 + k);
      step();
    end
    #1;
    check("burst_wrap", req_ready, 4'b0001);
    step();
    idle();

    // Write then read back: response 2 cycles after the read grant.
    set_req(0, 1'b1, 1, 32'hA5A50001);
    step();
    idle();
    set_req(2, 1'b0, 1, '0);
    #1;
    check("a5_grant", req_ready[2], 1'b1);
    step();
    idle();
    #1;
    check("a5_early", rsp_valid[2], 1'b0);
    step();
    #1;
    check("a5_valid", rsp_valid[2], 1'b1);
    check("a5_data",  rsp_rdata[2*DW +: DW], 32'hA5A50001);
    step();

    // Same-cycle read and write of one address returns the old contents.
    set_req(0, 1'b1, 3, 32'hDEAD);
    step();
    idle();
    set_req(0, 1'b1, 3, 32'h1234);
    set_req(1, 1'b0, 3, '0);
    #1;
    check("rbw_grant", req_ready, 4'b0011);
    step();
    idle();
    step();
    #1;
    check("rbw_old", rsp_rdata[1*DW +: DW], 32'hDEAD);
    step();
    set_req(1, 1'b0, 3, '0);
    step();
    idle();
    step();
    #1;
    check("rbw_new", rsp_rdata[1*DW +: DW], 32'h1234);
    step();

    // Back-pressure on requester 1 while requester 2 keeps reading.
    do_reset();
    g2 = 0;
    a2 = 0;
    for (int c = 0; c <= 8; c++) begin
      idle();
      set_req(1, 1'b0, 0, '0);
      set_req(2, 1'b0, 2, '0);
      rsp_ready = (c < 7) ? 4'b1101 : 4'b1111;
      #1;
      if (c == 0) check("bp_first", req_ready[1], 1'b1);
      if (c >= 1 && c <= 7) check("bp_no_regrant", req_ready[1], 1'b0);
      if (c >= 2 && c <= 7) check("bp_hold", rsp_valid[1], 1'b1);
      if (c == 8) check("bp_regrant", req_ready[1], 1'b1);
      g2 += int'(req_ready[2]);
      a2 += int'(rsp_valid[2] & rsp_ready[2]);
      step();
    end
    check("bp_req2_grants", g2, 3);
    check("bp_req2_answers", a2, 2);
    idle();
    rsp_ready = '1;

    // Reset while a read is in flight; the lowest eligible index wins afterwards.
    do_reset();
    set_req(1, 1'b1, 0, 32'h55);
    set_req(3, 1'b0, 2, '0);
    step();
    idle();
    do_reset();
    set_req(0, 1'b1, 1, 32'h77);
    set_req(2, 1'b1, 2, 32'h88);
    set_req(1, 1'b0, 0, '0);
    set_req(3, 1'b0, 0, '0);
    #1;
    check("post_rst_grant", req_ready, 4'b0011);
    check("post_rst_rsp",   rsp_valid, 4'b0000);
    step();
    idle();
    step();
    step();

    // Random traffic; a requester holds its request while it is not granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i]          = ($urandom_range(0, 99) < 60);
          req_we[i]             = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      rsp_ready = NREQ'($urandom);
      if (n == 250) do_reset();
      step();
    end
    idle();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/srsw_port_arbiter.md
Name: srsw_port_arbiter

Overview:
- Shares one single-read/single-write memory among NREQ requesters. The memory is 2^AW x DW, with a registered read port of 1-cycle latency and zero on reset.
- Two independent round-robin arbiters: one for the write port, one for the read port. At most one write and one read are granted per cycle.
- Each requester has a one-entry response buffer with a valid/ready handshake.
- Sits between client logic and the memory instance; drives its wen/waddr/wdata/ren/raddr and consumes its rdata.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 2, memory address width
- DW, 32, memory data width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  per-requester request valid
- req_we  input  NREQ  1 = write request, 0 = read request
- req_addr  input  NREQ*AW  per-requester address; slice i = [i*AW +: AW]
- req_wdata  input  NREQ*DW  per-requester write data
- req_ready  output  NREQ  grant; one-hot within writes, one-hot within reads
- rsp_valid  output  NREQ  read response valid
- rsp_rdata  output  NREQ*DW  per-requester response data
- rsp_ready  input  NREQ  response accept
- mem_wen  output  1  memory write enable
- mem_waddr  output  AW  memory write address
- mem_wdata  output  DW  memory write data
- mem_ren  output  1  memory read enable
- mem_raddr  output  AW  memory read address
- mem_rdata  input  DW  memory registered read data

Behaviour:
- Reset values:
  - rsp_valid = 0, rsp_rdata = 0, pend = 0.
  - Both round-robin pointers = 0, so requester 0 has highest priority.
  - In-flight tag is cleared; in-flight read data is discarded.
  - Reset acts immediately, mid-operation included.
- Write eligibility: req_valid[i] & req_we[i].
- Read eligibility: req_valid[i] & ~req_we[i] & ~pend[i].
- Round-robin:
  - Search starts at the pointer and wraps mod NREQ.
  - After a grant to i, that arbiter's pointer becomes (i+1) mod NREQ. With no grant, the pointer is held.
- Grant timing:
  - req_ready and mem_* are combinational from the current inputs and state.
  - A transfer occurs when req_valid & req_ready. Requesters hold addr/data/we stable while valid & ~ready.
- Write grant to i in cycle T: mem_wen=1, mem_waddr/mem_wdata come from slice i. No response is generated.
- Read grant to i in cycle T:
  - mem_ren=1, mem_raddr = slice i.
  - pend[i] is set at the end of T.
  - In-flight tag = i, valid for cycle T+1.
- Cycle T+1: mem_rdata is captured into rbuf[i] at the end of T+1.
- Cycle T+2: rsp_valid[i]=1, rsp_rdata slice i = rbuf[i]. Minimum grant-to-response latency is 2 cycles.
- Response hold and release:
  - rsp_valid[i] holds until rsp_valid[i] & rsp_ready[i].
  - On that handshake rsp_valid[i] and pend[i] clear at the clock edge. The requester becomes read-eligible in the following cycle, not the handshake cycle.
- Idle ports: when no grant, mem_wen/mem_ren = 0 and mem addr/data outputs = 0.
- Same-cycle read and write to the same address: the read returns the OLD value. This is memory read-before-write; the block performs no forwarding.
- A requester can receive a write grant while its read response is pending.
- rsp_rdata slice i holds its last value after the handshake; it is don't-care while rsp_valid[i]=0.

Decomposition:
- Package srsw_arb_pkg: default NREQ/AW/DW constants and the slice-index helper function.
- Sub-module rr_arbiter (parameter N): eligible vector in; one-hot grant out; pointer register with async reset. Instantiated twice (read, write).

Test Plan:
- Reset with all inputs idle: every output is 0. Assert rst mid-run: outputs are 0 in the same cycle, before the next edge.
- All 4 requesters issue writes (addr i, data 0x100+i) continuously: grants go 0,1,2,3 on consecutive cycles with mem_wen=1 each cycle. The next burst starts at requester 0.
- Requester 0 writes 0xA5A50001 to addr 1, then requester 2 reads addr 1 (grant at T): rsp_valid[2]=1 at T+2 with data 0xA5A50001.
- Addr 3 holds 0xDEAD. In the same cycle requester 0 writes 0x1234 to addr 3 and requester 1 reads addr 3: response is 0xDEAD. A following read returns 0x1234.
- Requester 1 holds rsp_ready=0 for 5 cycles with its next read pending:
  - requester 1 gets no read grant while pend[1];
  - requester 2 reads are granted and answered;
  - requester 1 is re-granted the cycle after its handshake.
- Read granted at T, rst pulsed during T+1: rsp_valid stays 0, pointers return to 0, and the first post-reset grant goes to the lowest eligible index.
